// File: rtl/ahb_master.sv
// AHB-Lite single-transfer initiator: valid/ready commands in, NONSEQ/IDLE
// transfers out, one in-order response per command. Address/data phases pipelined.
module ahb_master (
    input  logic        hclk,
    input  logic        hreset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic [1:0]  hresp,
    input  logic [31:0] hrdata
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] RESP_ERR  = 2'b01;

    // address stage
    logic        a_valid_q, a_valid_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] a_wdata_q, a_wdata_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hold_q, hold_d;
    // data stage
    logic        d_valid_q, d_valid_d;
    logic [31:0] hwdata_q, hwdata_d;
    // response
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic err1;
    logic accept;

    // First cycle of a two-cycle ERROR response from the slave.
    assign err1      = d_valid_q & ~hready & (hresp == RESP_ERR);
    assign cmd_ready = hready & ~hold_q & ~err1;
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        a_valid_d   = a_valid_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        a_wdata_d   = a_wdata_q;
        hold_d      = hold_q;
        d_valid_d   = d_valid_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (hready) begin
            rsp_valid_d = d_valid_q;
            if (d_valid_q) begin
                rsp_rdata_d = hrdata;
                rsp_err_d   = (hresp == RESP_ERR);
            end

            // A held (cancelled) command does not advance; it is reissued.
            d_valid_d = a_valid_q & ~hold_q;
            if (a_valid_q && !hold_q) begin
                hwdata_d = a_wdata_q;
            end

            if (accept) begin
                a_valid_d = 1'b1;
                haddr_d   = cmd_addr;
                hwrite_d  = cmd_write;
                hsize_d   = cmd_size;
                a_wdata_d = cmd_wdata;
            end else if (hold_q) begin
                hold_d = 1'b0;
            end else begin
                a_valid_d = 1'b0;
            end
        end else if (err1 && a_valid_q) begin
            hold_d = 1'b1;
        end

        htrans_d = (a_valid_d && !hold_d) ? TR_NONSEQ : TR_IDLE;
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            a_valid_q   <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b010;
            a_wdata_q   <= '0;
            htrans_q    <= TR_IDLE;
            hold_q      <= 1'b0;
            d_valid_q   <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            a_wdata_q   <= a_wdata_d;
            htrans_q    <= htrans_d;
            hold_q      <= hold_d;
            d_valid_q   <= d_valid_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hburst    = 3'b000;
    assign hprot     = 4'b0011;
    assign hwdata    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: hand-timed AHB slave responses, fixed expectations.
module tb_ahb_master;

    logic        hclk = 1'b0;
    logic        hreset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans, hresp;
    logic        hwrite, hready;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    int n_chk = 0;
    int n_err = 0;

    ahb_master dut (
        .hclk(hclk), .hreset_n(hreset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic cmd(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_size  = sz;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic no_cmd();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_size  = 3'b010;
        cmd_addr  = '0;
        cmd_wdata = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " htrans"}, {30'd0, htrans}, 32'h0);
        check({tag, " haddr"}, haddr, 32'h0);
        check({tag, " hwrite"}, {31'd0, hwrite}, 32'h0);
        check({tag, " hsize"}, {29'd0, hsize}, 32'h2);
        check({tag, " hwdata"}, hwdata, 32'h0);
        check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'h0);
        check({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
        check({tag, " rsp_err"}, {31'd0, rsp_err}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [31:0] rd [3];

    initial begin
        hreset_n = 1'b0;
        hready   = 1'b1;
        hresp    = 2'b00;
        hrdata   = '0;
        no_cmd();
        rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33;

        // ---- reset state
        step(); step();
        check_reset_outputs("rst");
        check("rst hburst", {29'd0, hburst}, 32'h0);
        check("rst hprot", {28'd0, hprot}, 32'h3);
        #3 hreset_n = 1'b1;
        step();
        hready = 1'b0; #1;
        check("rst cmd_ready lo", {31'd0, cmd_ready}, 32'h0);
        hready = 1'b1; #1;
        check("rst cmd_ready hi", {31'd0, cmd_ready}, 32'h1);

        // ---- single write, zero wait
        cmd(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF); #1;
        check("wr cmd_ready", {31'd0, cmd_ready}, 32'h1);
        step(); no_cmd();
        check("wr htrans", {30'd0, htrans}, 32'h2);
        check("wr haddr", haddr, 32'h10);
        check("wr hwrite", {31'd0, hwrite}, 32'h1);
        check("wr hsize", {29'd0, hsize}, 32'h2);
        step();
        check("wr htrans idle", {30'd0, htrans}, 32'h0);
        check("wr hwdata", hwdata, 32'hDEAD_BEEF);
        check("wr rsp early", {31'd0, rsp_valid}, 32'h0);
        step();
        check("wr rsp_valid", {31'd0, rsp_valid}, 32'h1);
        check("wr rsp_err", {31'd0, rsp_err}, 32'h0);
        step();
        check("wr rsp pulse", {31'd0, rsp_valid}, 32'h0);

        // ---- back-to-back reads 0x0/0x4/0x8
        for (int i = 0; i < 7; i++) begin
            step();
            check("b2b htrans", {30'd0, htrans}, (i >= 1 && i <= 3) ? 32'h2 : 32'h0);
            if (i >= 1 && i <= 3) check("b2b haddr", haddr, 32'(4 * (i - 1)));
            check("b2b rsp_valid", {31'd0, rsp_valid}, (i >= 3 && i <= 5) ? 32'h1 : 32'h0);
            if (i >= 3 && i <= 5) check("b2b rsp_rdata", rsp_rdata, rd[i-3]);
            hrdata = (i >= 2 && i <= 4) ? rd[i-2] : 32'h0;
            if (i < 3) begin
                cmd(1'b0, 3'b010, 32'(4 * i), 32'h0); #1;
                check("b2b cmd_ready", {31'd0, cmd_ready}, 32'h1);
            end else begin
                no_cmd();
            end
        end

        // ---- wait states: read 0x100 stalled 2 cycles, 0x104 queued
        step();
        cmd(1'b0, 3'b010, 32'h100, 32'h0);
        step();
        check("ws htrans 100", {30'd0, htrans}, 32'h2);
        check("ws haddr 100", haddr, 32'h100);
        cmd(1'b0, 3'b010, 32'h104, 32'h0);
        step();
        no_cmd(); hready = 1'b0; #1;
        check("ws cmd_ready", {31'd0, cmd_ready}, 32'h0);
        check("ws haddr w1", haddr, 32'h104);
        step();
        check("ws htrans w2", {30'd0, htrans}, 32'h2);
        check("ws haddr w2", haddr, 32'h104);
        check("ws rsp w2", {31'd0, rsp_valid}, 32'h0);
        step();
        check("ws htrans held", {30'd0, htrans}, 32'h2);
        check("ws haddr held", haddr, 32'h104);
        check("ws rsp still", {31'd0, rsp_valid}, 32'h0);
        hready = 1'b1; hrdata = 32'hAA;
        step();
        check("ws rsp 100", {31'd0, rsp_valid}, 32'h1);
        check("ws rdata 100", rsp_rdata, 32'hAA);
        check("ws htrans idle", {30'd0, htrans}, 32'h0);
        hrdata = 32'hBB;
        step();
        check("ws rsp 104", {31'd0, rsp_valid}, 32'h1);
        check("ws rdata 104", rsp_rdata, 32'hBB);
        hrdata = 32'h0;
        step();
        check("ws rsp done", {31'd0, rsp_valid}, 32'h0);

        // ---- ERROR on write 0x20 with read 0x24 pipelined
        cmd(1'b1, 3'b010, 32'h20, 32'h55);
        step();
        cmd(1'b0, 3'b010, 32'h24, 32'h0);
        step();
        check("err haddr 24", haddr, 32'h24);
        no_cmd(); hready = 1'b0; hresp = 2'b01; #1;
        check("err1 cmd_ready", {31'd0, cmd_ready}, 32'h0);
        step();
        check("err htrans idle", {30'd0, htrans}, 32'h0);
        check("err haddr kept", haddr, 32'h24);
        check("err rsp none", {31'd0, rsp_valid}, 32'h0);
        hready = 1'b1; #1;
        check("err2 cmd_ready", {31'd0, cmd_ready}, 32'h0);
        step();
        hresp = 2'b00;
        check("err rsp_valid", {31'd0, rsp_valid}, 32'h1);
        check("err rsp_err", {31'd0, rsp_err}, 32'h1);
        check("err reissue htrans", {30'd0, htrans}, 32'h2);
        check("err reissue haddr", haddr, 32'h24);
        check("err reissue hwrite", {31'd0, hwrite}, 32'h0);
        step();
        check("err reissue dp rsp", {31'd0, rsp_valid}, 32'h0);
        check("err reissue idle", {30'd0, htrans}, 32'h0);
        hrdata = 32'h77;
        step();
        check("err 24 rsp_valid", {31'd0, rsp_valid}, 32'h1);
        check("err 24 rsp_err", {31'd0, rsp_err}, 32'h0);
        check("err 24 rdata", rsp_rdata, 32'h77);
        hrdata = 32'h0;

        // ---- byte write
        step();
        cmd(1'b1, 3'b000, 32'h3, 32'hAB00_0000);
        step(); no_cmd();
        check("byte hsize", {29'd0, hsize}, 32'h0);
        check("byte haddr", haddr, 32'h3);
        check("byte htrans", {30'd0, htrans}, 32'h2);
        step();
        check("byte hwdata", hwdata, 32'hAB00_0000);
        step();
        check("byte rsp", {31'd0, rsp_valid}, 32'h1);

        // ---- ERROR with empty address stage: no hold, no extra bubble
        step();
        cmd(1'b1, 3'b010, 32'h40, 32'h1);
        step(); no_cmd();
        step();
        hready = 1'b0; hresp = 2'b01;
        step();
        hready = 1'b1; #1;
        check("errnh cmd_ready", {31'd0, cmd_ready}, 32'h1);
        check("errnh htrans", {30'd0, htrans}, 32'h0);
        step();
        hresp = 2'b00;
        check("errnh rsp_valid", {31'd0, rsp_valid}, 32'h1);
        check("errnh rsp_err", {31'd0, rsp_err}, 32'h1);

        // ---- reset mid-transfer
        step();
        cmd(1'b1, 3'b001, 32'h80, 32'h1234);
        step(); no_cmd();
        check("mrst pre htrans", {30'd0, htrans}, 32'h2);
        #3 hreset_n = 1'b0;
        #1;
        check_reset_outputs("mrst");
        @(posedge hclk); #2 hreset_n = 1'b1;
        step();
        check("mrst dropped1", {31'd0, rsp_valid}, 32'h0);
        step();
        check("mrst dropped2", {31'd0, rsp_valid}, 32'h0);
        check("mrst htrans", {30'd0, htrans}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
